// File: rtl/useq_next_address.sv
// rtl/useq_next_address.sv - microprogram sequencer selecting the next control-store address
module useq_next_address #(
  parameter int Direction_BUS_WIDTH = 11,
  parameter int STACK_DEPTH         = 4
) (
  input  logic                           USEQ_CLOCK_50,
  input  logic                           USEQ_RESET_InHigh,
  input  logic                           USEQ_Step_IN,
  input  logic [2:0]                     USEQ_Op_IN,
  input  logic                           USEQ_Cond_IN,
  input  logic                           USEQ_Ready_IN,
  input  logic [Direction_BUS_WIDTH-1:0] USEQ_Incremented_IN,
  input  logic [Direction_BUS_WIDTH-1:0] USEQ_Jump_IN,
  output logic [Direction_BUS_WIDTH-1:0] USEQ_Direccion_OUT,
  output logic [2:0]                     USEQ_Depth_OUT,
  output logic                           USEQ_Busy_OUT,
  output logic                           USEQ_Overflow_OUT,
  output logic                           USEQ_Underflow_OUT
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HOLD = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [2:0] OP_NEXT   = 3'b000;
  localparam logic [2:0] OP_JUMP   = 3'b001;
  localparam logic [2:0] OP_BRANCH = 3'b010;
  localparam logic [2:0] OP_CALL   = 3'b011;
  localparam logic [2:0] OP_RETURN = 3'b100;
  localparam logic [2:0] OP_WAIT   = 3'b101;

  state_t                         state_q, state_d;
  logic [Direction_BUS_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]                     depth_q, depth_d;
  logic                           busy_q, busy_d;
  logic                           ovf_q, ovf_d;
  logic                           unf_q, unf_d;
  logic                           push;
  logic [Direction_BUS_WIDTH-1:0] top_of_stack;
  logic [Direction_BUS_WIDTH-1:0] stack_mem [STACK_DEPTH];

  // Entry depth-1 is the top; the loop keeps the 3-bit depth from indexing past the array.
  always_comb begin
    top_of_stack = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (depth_q == 3'(i + 1)) top_of_stack = stack_mem[i];
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    depth_d = depth_q;
    busy_d  = busy_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (USEQ_Step_IN) begin
          case (USEQ_Op_IN)
            OP_JUMP:   addr_d = USEQ_Jump_IN;
            OP_BRANCH: addr_d = USEQ_Cond_IN ? USEQ_Jump_IN : USEQ_Incremented_IN;
            OP_CALL: begin
              if (depth_q < 3'(STACK_DEPTH)) begin
                push    = 1'b1;
                depth_d = depth_q + 3'd1;
                addr_d  = USEQ_Jump_IN;
              end else begin
                ovf_d   = 1'b1;
                state_d = ST_HALT;
              end
            end
            OP_RETURN: begin
              if (depth_q != 3'd0) begin
                addr_d  = top_of_stack;
                depth_d = depth_q - 3'd1;
              end else begin
                unf_d   = 1'b1;
                state_d = ST_HALT;
              end
            end
            OP_WAIT: begin
              if (USEQ_Ready_IN) begin
                addr_d = USEQ_Incremented_IN;
              end else begin
                busy_d  = 1'b1;
                state_d = ST_HOLD;
              end
            end
            default:   addr_d = USEQ_Incremented_IN;
          endcase
        end
      end
      ST_HOLD: begin
        if (USEQ_Ready_IN) begin
          addr_d  = USEQ_Incremented_IN;
          busy_d  = 1'b0;
          state_d = ST_RUN;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge USEQ_CLOCK_50) begin
    if (USEQ_RESET_InHigh) begin
      state_q <= ST_RUN;
      addr_q  <= '0;
      depth_q <= 3'd0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      depth_q <= depth_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack contents need no reset; depth alone decides which entries are live.
  always_ff @(posedge USEQ_CLOCK_50) begin
    if (push && !USEQ_RESET_InHigh) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        if (depth_q == 3'(i)) stack_mem[i] <= USEQ_Incremented_IN;
      end
    end
  end

  assign USEQ_Direccion_OUT = addr_q;
  assign USEQ_Depth_OUT     = depth_q;
  assign USEQ_Busy_OUT      = busy_q;
  assign USEQ_Overflow_OUT  = ovf_q;
  assign USEQ_Underflow_OUT = unf_q;

endmodule

// File: tb/tb_useq_next_address.sv
// tb/tb_useq_next_address.sv - directed self-checking bench for useq_next_address
module tb_useq_next_address;

  localparam logic [2:0] OP_NEXT   = 3'b000;
  localparam logic [2:0] OP_JUMP   = 3'b001;
  localparam logic [2:0] OP_BRANCH = 3'b010;
  localparam logic [2:0] OP_CALL   = 3'b011;
  localparam logic [2:0] OP_RETURN = 3'b100;
  localparam logic [2:0] OP_WAIT   = 3'b101;

  logic        clk = 1'b0;
  logic        rst, step, cond, ready;
  logic [2:0]  op;
  logic [10:0] inc, jmp;
  logic [10:0] addr;
  logic [2:0]  depth;
  logic        busy, ovf, unf;
  logic [16:0] obs, exp_v;
  int          tests_run = 0;
  int          tests_failed = 0;

  useq_next_address #(.Direction_BUS_WIDTH(11), .STACK_DEPTH(4)) dut (
    .USEQ_CLOCK_50      (clk),
    .USEQ_RESET_InHigh  (rst),
    .USEQ_Step_IN       (step),
    .USEQ_Op_IN         (op),
    .USEQ_Cond_IN       (cond),
    .USEQ_Ready_IN      (ready),
    .USEQ_Incremented_IN(inc),
    .USEQ_Jump_IN       (jmp),
    .USEQ_Direccion_OUT (addr),
    .USEQ_Depth_OUT     (depth),
    .USEQ_Busy_OUT      (busy),
    .USEQ_Overflow_OUT  (ovf),
    .USEQ_Underflow_OUT (unf)
  );

  always #5 clk = ~clk;

  // {address, depth, busy, overflow, underflow}
  assign obs = {addr, depth, busy, ovf, unf};

  task automatic cyc(input logic s, input logic [2:0] o, input logic c, input logic r,
                     input logic [10:0] i, input logic [10:0] j);
    rst = 1'b0; step = s; op = o; cond = c; ready = r; inc = i; jmp = j;
    @(posedge clk); #1;
  endtask

  task automatic rst_cyc(input logic s, input logic [2:0] o);
    rst = 1'b1; step = s; op = o; cond = 1'b0; ready = 1'b0; inc = 11'h7AB; jmp = 11'h2CD;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_cyc(1'b0, OP_NEXT);
    rst_cyc(1'b0, OP_NEXT);
    exp_v = {11'h000, 3'd0, 1'b0, 1'b0, 1'b0};
    tests_run++;
    if (obs !== exp_v) begin tests_failed++; $display("FAIL reset_state: got %h expected %h", obs, exp_v); end
  endtask

  task automatic test_next_jump_branch;
    cyc(1'b1, OP_JUMP, 1'b0, 1'b0, 11'h001, 11'h010);
    exp_v = {11'h010, 3'd0, 3'b000};
    tests_run++;
    if (obs !== exp_v) begin tests_failed++; $display("FAIL jump_010: got %h expected %h", obs, exp_v); end
    cyc(1'b1, OP_NEXT, 1'b0, 1'b0, 11'h011, 11'h555);
    exp_v = {11'h011, 3'd0, 3'b000};
    tests_run++;
    if (obs !== exp_v) begin tests_failed++; $display("FAIL next_011: got %h expected %h", obs, exp_v); end
    cyc(1'b0, OP_JUMP, 1'b0, 1'b0, 11'h012, 11'h666);
    exp_v = {11'h011, 3'd0, 3'b000};
    tests_run++;
    if (obs !== exp_v) begin tests_failed++; $display("FAIL step_low_hold: got %h expected %h", obs, exp_v); end
    cyc(1'b1, OP_JUMP, 1'b0, 1'b0, 11'h012, 11'h3A0);
    exp_v = {11'h3A0, 3'd0, 3'b000};
    tests_run++;
    if (obs !== exp_v) begin tests_failed++; $display("FAIL jump_3a0: got %h expected %h", obs, exp_v); end
    cyc(1'b1, OP_BRANCH, 1'b0, 1'b0, 11'h3A1, 11'h100);
    exp_v = {11'h3A1, 3'd0, 3'b000};
    tests_run++;
    if (obs !== exp_v) begin tests_failed++; $display("FAIL branch_not_taken: got %h expected %h", obs, exp_v); end
    cyc(1'b1, OP_BRANCH, 1'b1, 1'b0, 11'h3A2, 11'h100);
    exp_v = {11'h100, 3'd0, 3'b000};
    tests_run++;
    if (obs !== exp_v) begin tests_failed++; $display("FAIL branch_taken: got %h expected %h", obs, exp_v); end
    cyc(1'b1, 3'b110, 1'b1, 1'b0, 11'h101, 11'h444);
    exp_v = {11'h101, 3'd0, 3'b000};
    tests_run++;
    if (obs !== exp_v) begin tests_failed++; $display("FAIL op110_as_next: got %h expected %h", obs, exp_v); end
    cyc(1'b1, OP_JUMP, 1'b0, 1'b0, 11'h102, 11'h7FF);
    cyc(1'b1, OP_NEXT, 1'b0, 1'b0, 11'h000, 11'h123);
    exp_v = {11'h000, 3'd0, 3'b000};
    tests_run++;
    if (obs !== exp_v) begin tests_failed++; $display("FAIL next_wrap: got %h expected %h", obs, exp_v); end
  endtask

  task automatic test_call_return;
    cyc(1'b1, OP_JUMP, 1'b0, 1'b0, 11'h001, 11'h050);
    cyc(1'b1, OP_CALL, 1'b0, 1'b0, 11'h051, 11'h200);
    exp_v = {11'h200, 3'd1, 3'b000};
    tests_run++;
    if (obs !== exp_v) begin tests_failed++; $display("FAIL call_200: got %h expected %h", obs, exp_v); end
    cyc(1'b1, OP_NEXT, 1'b0, 1'b0, 11'h201, 11'h000);
    cyc(1'b1, OP_CALL, 1'b0, 1'b0, 11'h202, 11'h300);
    exp_v = {11'h300, 3'd2, 3'b000};
    tests_run++;
    if (obs !== exp_v) begin tests_failed++; $display("FAIL call_300: got %h expected %h", obs, exp_v); end
    cyc(1'b1, OP_RETURN, 1'b0, 1'b0, 11'h301, 11'h0AA);
    exp_v = {11'h202, 3'd1, 3'b000};
    tests_run++;
    if (obs !== exp_v) begin tests_failed++; $display("FAIL return_202: got %h expected %h", obs, exp_v); end
    cyc(1'b1, OP_RETURN, 1'b0, 1'b0, 11'h203, 11'h0AA);
    exp_v = {11'h051, 3'd0, 3'b000};
    tests_run++;
    if (obs !== exp_v) begin tests_failed++; $display("FAIL return_051: got %h expected %h", obs, exp_v); end
  endtask

  task automatic test_reset_mid_call;
    cyc(1'b1, OP_CALL, 1'b0, 1'b0, 11'h052, 11'h210);
    cyc(1'b1, OP_CALL, 1'b0, 1'b0, 11'h211, 11'h220);
    exp_v = {11'h220, 3'd2, 3'b000};
    tests_run++;
    if (obs !== exp_v) begin tests_failed++; $display("FAIL pre_reset_depth2: got %h expected %h", obs, exp_v); end
    rst_cyc(1'b1, OP_CALL);
    exp_v = {11'h000, 3'd0, 3'b000};
    tests_run++;
    if (obs !== exp_v) begin tests_failed++; $display("FAIL reset_first_edge: got %h expected %h", obs, exp_v); end
    rst_cyc(1'b1, OP_CALL);
    tests_run++;
    if (obs !== exp_v) begin tests_failed++; $display("FAIL reset_second_edge: got %h expected %h", obs, exp_v); end
  endtask

  task automatic test_overflow;
    cyc(1'b1, OP_CALL, 1'b0, 1'b0, 11'h001, 11'h100);
    cyc(1'b1, OP_CALL, 1'b0, 1'b0, 11'h101, 11'h110);
    cyc(1'b1, OP_CALL, 1'b0, 1'b0, 11'h111, 11'h120);
    cyc(1'b1, OP_CALL, 1'b0, 1'b0, 11'h121, 11'h130);
    exp_v = {11'h130, 3'd4, 3'b000};
    tests_run++;
    if (obs !== exp_v) begin tests_failed++; $display("FAIL four_calls: got %h expected %h", obs, exp_v); end
    cyc(1'b1, OP_CALL, 1'b0, 1'b0, 11'h131, 11'h140);
    exp_v = {11'h130, 3'd4, 1'b0, 1'b1, 1'b0};
    tests_run++;
    if (obs !== exp_v) begin tests_failed++; $display("FAIL overflow_call: got %h expected %h", obs, exp_v); end
    cyc(1'b1, OP_NEXT, 1'b0, 1'b0, 11'h131, 11'h000);
    cyc(1'b1, OP_RETURN, 1'b0, 1'b1, 11'h131, 11'h000);
    tests_run++;
    if (obs !== exp_v) begin tests_failed++; $display("FAIL overflow_halt_frozen: got %h expected %h", obs, exp_v); end
    rst_cyc(1'b0, OP_NEXT);
    exp_v = {11'h000, 3'd0, 3'b000};
    tests_run++;
    if (obs !== exp_v) begin tests_failed++; $display("FAIL overflow_reset_clear: got %h expected %h", obs, exp_v); end
  endtask

  task automatic test_underflow;
    cyc(1'b1, OP_JUMP, 1'b0, 1'b0, 11'h001, 11'h020);
    cyc(1'b1, OP_RETURN, 1'b0, 1'b0, 11'h021, 11'h000);
    exp_v = {11'h020, 3'd0, 1'b0, 1'b0, 1'b1};
    tests_run++;
    if (obs !== exp_v) begin tests_failed++; $display("FAIL underflow_return: got %h expected %h", obs, exp_v); end
    cyc(1'b1, OP_JUMP, 1'b0, 1'b0, 11'h021, 11'h3FF);
    cyc(1'b1, OP_CALL, 1'b0, 1'b0, 11'h021, 11'h3FF);
    tests_run++;
    if (obs !== exp_v) begin tests_failed++; $display("FAIL underflow_halt_frozen: got %h expected %h", obs, exp_v); end
    rst_cyc(1'b0, OP_NEXT);
  endtask

  task automatic test_wait;
    cyc(1'b1, OP_JUMP, 1'b0, 1'b1, 11'h001, 11'h040);
    cyc(1'b1, OP_WAIT, 1'b0, 1'b0, 11'h041, 11'h000);
    exp_v = {11'h040, 3'd0, 1'b1, 1'b0, 1'b0};
    tests_run++;
    if (obs !== exp_v) begin tests_failed++; $display("FAIL wait_enter_hold: got %h expected %h", obs, exp_v); end
    for (int k = 0; k < 2; k++) begin
      cyc(k[0], OP_JUMP, 1'b1, 1'b0, 11'h041, 11'h3FF);
      tests_run++;
      if (obs !== exp_v) begin tests_failed++; $display("FAIL wait_hold_%0d: got %h expected %h", k, obs, exp_v); end
    end
    cyc(1'b1, OP_JUMP, 1'b1, 1'b1, 11'h041, 11'h3FF);
    exp_v = {11'h041, 3'd0, 3'b000};
    tests_run++;
    if (obs !== exp_v) begin tests_failed++; $display("FAIL wait_release: got %h expected %h", obs, exp_v); end
  endtask

  task automatic test_back_to_back;
    cyc(1'b1, OP_WAIT, 1'b0, 1'b1, 11'h042, 11'h000);
    exp_v = {11'h042, 3'd0, 3'b000};
    tests_run++;
    if (obs !== exp_v) begin tests_failed++; $display("FAIL wait_ready_high: got %h expected %h", obs, exp_v); end
    cyc(1'b1, OP_CALL, 1'b0, 1'b1, 11'h043, 11'h500);
    cyc(1'b1, OP_WAIT, 1'b0, 1'b1, 11'h501, 11'h000);
    cyc(1'b1, OP_RETURN, 1'b0, 1'b1, 11'h502, 11'h000);
    exp_v = {11'h043, 3'd0, 3'b000};
    tests_run++;
    if (obs !== exp_v) begin tests_failed++; $display("FAIL call_wait_return: got %h expected %h", obs, exp_v); end
  endtask

  initial begin
    rst = 1'b1; step = 1'b0; op = OP_NEXT; cond = 1'b0; ready = 1'b0;
    inc = 11'h000; jmp = 11'h000;
    test_reset();
    test_next_jump_branch();
    test_call_return();
    test_reset_mid_call();
    test_overflow();
    test_underflow();
    test_wait();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/useq_next_address.md
# useq_next_address

- Microprogram sequencer that drives the control-store micro-address of the micro-datapath.
- Sits downstream of the address incrementer and consumes its "current + 1" result.
- Each cycle it selects the next micro-address from: the increment, a jump target, a conditional branch, a call/return through a small hardware return stack, or a wait on an external ready handshake.
- Its address output feeds both the control-store ROM and the incrementer input, closing the micro-address loop.

## Interface

Parameters:
- Direction_BUS_WIDTH, 11, micro-address width in bits.
- STACK_DEPTH, 4, number of return-stack entries; legal range 1..7.

Ports:
- USEQ_CLOCK_50  input  1  system clock; all state changes on its rising edge.
- USEQ_RESET_InHigh  input  1  reset, synchronous, active-high.
- USEQ_Step_IN  input  1  advance enable in RUN; low = hold address and stack.
- USEQ_Op_IN  input  3  sequencing op:
  - 000 NEXT, 001 JUMP, 010 BRANCH, 011 CALL, 100 RETURN, 101 WAIT.
  - 110 and 111 behave as NEXT.
- USEQ_Cond_IN  input  1  branch condition for BRANCH.
- USEQ_Ready_IN  input  1  external ready for WAIT.
- USEQ_Incremented_IN  input  Direction_BUS_WIDTH  current address + 1, supplied by the incrementer.
- USEQ_Jump_IN  input  Direction_BUS_WIDTH  jump/branch/call target from the microinstruction.
- USEQ_Direccion_OUT  output  Direction_BUS_WIDTH  registered current micro-address.
- USEQ_Depth_OUT  output  3  registered return-stack occupancy, 0..STACK_DEPTH.
- USEQ_Busy_OUT  output  1  high while in HOLD.
- USEQ_Overflow_OUT  output  1  sticky: CALL attempted with stack full.
- USEQ_Underflow_OUT  output  1  sticky: RETURN attempted with stack empty.

## Operation

States: RUN, HOLD, HALT.

- **Reset** (synchronous; overrides every other input and any in-progress op): next edge forces
  - state RUN;
  - USEQ_Direccion_OUT = 0;
  - depth = 0;
  - Busy = 0, Overflow = 0, Underflow = 0.
  - Stack contents are don't-care.
- **RUN, Step = 0**: every register is held.
- **RUN, Step = 1**, op sampled on the edge:
  - NEXT: address <= Incremented_IN.
  - JUMP: address <= Jump_IN.
  - BRANCH: address <= Cond_IN ? Jump_IN : Incremented_IN.
  - CALL, depth < STACK_DEPTH: push Incremented_IN, depth += 1, address <= Jump_IN.
  - CALL, depth == STACK_DEPTH: no push, address held, Overflow <= 1, state -> HALT.
  - RETURN, depth > 0: address <= top of stack, depth -= 1.
  - RETURN, depth == 0: address held, Underflow <= 1, state -> HALT.
  - WAIT, Ready_IN = 1: address <= Incremented_IN (behaves as NEXT).
  - WAIT, Ready_IN = 0: address held, state -> HOLD, Busy <= 1.
- **HOLD**:
  - Step_IN and Op_IN are ignored; address is held.
  - On the first edge with Ready_IN = 1: address <= Incremented_IN, state -> RUN, Busy <= 0.
- **HALT**: address, stack, depth and flags are frozen until reset.
- **Stack**: LIFO. Push and pop never occur on the same edge. Top-of-stack readout is combinational from the stack array indexed by depth-1.
- **Width**:
  - No internal adder. Incremented_IN is taken as supplied; wrap 0x7FF -> 0x000 is the incrementer's responsibility and passes through unchanged.
  - Jump_IN is used unmodified.

## Timing

- Single-cycle decision: op/inputs sampled at rising edge N; USEQ_Direccion_OUT valid after edge N.
- The incrementer must present address + 1 on USEQ_Incremented_IN before edge N+1.
- All outputs are registered. Busy, Depth and the flags update on the same edge as the address.
- WAIT with Ready already high costs 1 cycle.
- WAIT with Ready low costs 1 + k cycles, where k = number of HOLD edges until Ready is seen high.
- Ready must be held high until the edge that exits HOLD; a pulse between edges is missed.
- Overflow/Underflow rise on the offending edge and stay high until reset.

## Test plan

- **Reset**: assert reset for 2 cycles mid-CALL sequence with depth 2 -> address 0x000, depth 0, all flags 0 after the first reset edge.
- **NEXT/JUMP/BRANCH**:
  - From 0x010: NEXT with Incremented 0x011 -> 0x011.
  - JUMP to 0x3A0 -> 0x3A0.
  - BRANCH to 0x100: Cond = 0 -> Incremented value; Cond = 1 -> 0x100.
  - NEXT from 0x7FF with Incremented 0x000 -> 0x000.
- **Nested call/return**:
  - CALL 0x200 from 0x050, then CALL 0x300 from 0x201 -> depth 2.
  - RETURN -> 0x202, depth 1.
  - RETURN -> 0x051, depth 0.
- **Overflow**: 4 CALLs then a 5th CALL -> address unchanged, depth 4, Overflow 1, HALT. Further NEXT ops leave the address frozen until reset.
- **Underflow**: RETURN at depth 0 from 0x020 -> address 0x020, Underflow 1, HALT.
- **WAIT handshake**:
  - WAIT at 0x040 with Ready = 0 for 3 edges, Step toggling -> Busy high, address 0x040 throughout.
  - Ready = 1 -> address 0x041 on the next edge, Busy 0.
  - WAIT with Ready = 1 -> advances in 1 cycle, Busy never asserted.
